// File: rtl/viterbi_pkg.sv
// Shared widths and the scheduler state encoding for the Viterbi job scheduler.
package viterbi_pkg;

  localparam int CW_W  = 8;
  localparam int NIB_W = 4;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/codeword_fifo.sv
// Synchronous codeword FIFO with an extra wrap bit on each pointer to tell full from empty.
module codeword_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_wr,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_rd,
  output logic [W-1:0] o_rd_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_wr;
  logic         w_rd;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign w_wr      = i_wr & ~o_full;
  assign w_rd      = i_rd & ~o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: clearing the pointers already discards the contents.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/viterbi_job_scheduler.sv
// Queues received codewords and feeds them one by one to the Viterbi decoder with a per-job timeout.
// Optional feature: PARITY_CHECK_EN drops words whose bit 8 is not the even parity of bits 7:0.
//
// state | meaning
// IDLE  | decoder held clear, pop next codeword when the FIFO has one
// CLEAR | decoder held clear for CLR_CYC cycles with the new codeword on dec_data
// RUN   | dec_start high, waiting for dec_ready or the timeout
// HOLD  | decoder cleared, decoded nibble waiting for the consumer
module viterbi_job_scheduler
  import viterbi_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int CLR_CYC = 2,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             start,
  input  logic             in_valid,
  input  logic [CW_W:0]    in_word,
  output logic             in_full,
  output logic             dec_start,
  output logic [CW_W-1:0]  dec_data,
  input  logic             dec_ready,
  input  logic [NIB_W-1:0] dec_out,
  output logic             out_valid,
  output logic [NIB_W-1:0] out_data,
  input  logic             out_ready,
  output logic             err_tmo,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(CLR_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TIMEOUT);

  state_t            r_state;
  logic [CNT_W-1:0]  r_clr_cnt;
  logic [CNT_W-1:0]  r_tmo_cnt;
  logic              r_dec_start;
  logic [CW_W-1:0]   r_dec_data;
  logic              r_out_valid;
  logic [NIB_W-1:0]  r_out_data;
  logic              r_err_tmo;
  logic [CNT_W-1:0]  r_drop_cnt;

  logic              w_full;
  logic              w_empty;
  logic [CW_W-1:0]   w_rd_data;
  logic              w_par_ok;
  logic              w_wr;
  logic              w_drop;
  logic              w_pop;

`ifdef PARITY_CHECK_EN
  assign w_par_ok = (in_word[CW_W] == ^in_word[CW_W-1:0]);
`else
  logic w_unused_par;
  assign w_par_ok     = 1'b1;
  assign w_unused_par = in_word[CW_W];
`endif

  // A word that is both full-dropped and parity-failed counts once.
  assign w_wr   = in_valid & ~w_full & w_par_ok;
  assign w_drop = in_valid & (w_full | ~w_par_ok);
  assign w_pop  = (r_state == IDLE) & ~w_empty;

  codeword_fifo #(
    .DEPTH (DEPTH),
    .W     (CW_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (start),
    .i_wr      (w_wr),
    .i_wr_data (in_word[CW_W-1:0]),
    .i_rd      (w_pop),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      r_state     <= IDLE;
      r_clr_cnt   <= '0;
      r_tmo_cnt   <= '0;
      r_dec_start <= 1'b0;
      r_dec_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_err_tmo   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_dec_start <= 1'b0;
          if (w_pop) begin
            r_dec_data <= w_rd_data;
            r_clr_cnt  <= CLR_LOAD;
            r_state    <= CLEAR;
          end
        end
        CLEAR: begin
          if (r_clr_cnt == '0) begin
            r_dec_start <= 1'b1;
            r_tmo_cnt   <= '0;
            r_state     <= RUN;
          end else begin
            r_clr_cnt <= r_clr_cnt - CNT_W'(1);
          end
        end
        RUN: begin
          if (dec_ready) begin
            r_out_data  <= dec_out;
            r_out_valid <= 1'b1;
            r_dec_start <= 1'b0;
            r_state     <= HOLD;
          end else if (r_tmo_cnt == TMO_MAX) begin
            r_err_tmo   <= 1'b1;
            r_dec_start <= 1'b0;
            r_state     <= IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  assign in_full   = w_full;
  assign dec_start = r_dec_start;
  assign dec_data  = r_dec_data;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign err_tmo   = r_err_tmo;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_viterbi_job_scheduler.sv
// Self-checking bench: decoder stand-in, ordered job scoreboard and directed plus random traffic.
// Builds with or without PARITY_CHECK_EN; the word-acceptance model follows the same switch.
module tb_viterbi_job_scheduler;

  localparam int DEPTH   = 4;
  localparam int CLR_CYC = 2;
  localparam int TIMEOUT = 255;

  logic       clk;
  logic       start;
  logic       in_valid;
  logic [8:0] in_word;
  logic       in_full;
  logic       dec_start;
  logic [7:0] dec_data;
  logic       dec_ready;
  logic [3:0] dec_out;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready;
  logic       err_tmo;
  logic [7:0] drop_cnt;

  viterbi_job_scheduler #(
    .DEPTH   (DEPTH),
    .CLR_CYC (CLR_CYC),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .start     (start),
    .in_valid  (in_valid),
    .in_word   (in_word),
    .in_full   (in_full),
    .dec_start (dec_start),
    .dec_data  (dec_data),
    .dec_ready (dec_ready),
    .dec_out   (dec_out),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .err_tmo   (err_tmo),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: accepted words in order, expected nibbles in order.
  logic [7:0] exp_q [$];
  logic [3:0] out_q [$];
  int         exp_drop = 0;
  int         n_acc = 0;
  int         n_out = 0;
  bit         mon_en = 1'b1;
  bit         ds_prev = 1'b0;
  logic [7:0] mon_w;

  // Decoder stand-in controls.
  int dec_lat  = 1;
  bit dec_hang = 1'b0;
  bit job_hang = 1'b0;
  bit spur     = 1'b0;
  int run_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_dec(input logic [7:0] w);
    return w[7:4] ^ w[3:0] ^ 4'h6;
  endfunction

  function automatic logic [8:0] mkw(input logic [7:0] b);
    return {^b, b};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [8:0] w, input bit full_exp);
    bit par_ok;
`ifdef PARITY_CHECK_EN
    par_ok = (w[8] == ^w[7:0]);
`else
    par_ok = 1'b1;
`endif
    in_valid = 1'b1;
    in_word  = w;
    if (full_exp || !par_ok) begin
      if (exp_drop < 255) exp_drop++;
    end else begin
      exp_q.push_back(w[7:0]);
      n_acc++;
    end
    tick;
  endtask

  task automatic send(input logic [8:0] w);
    drive_word(w, 1'b0);
    in_valid = 1'b0;
  endtask

  task automatic wait_ds(input int budget);
    int n = 0;
    while (!dec_start && n < budget) begin tick; n++; end
    chk("wait_dec_start", dec_start, 1);
  endtask

  task automatic wait_out(input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin tick; n++; end
    chk("wait_out_valid", out_valid, 1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() + out_q.size()) != 0 && n < budget) begin tick; n++; end
    chk("drain_pending", 32'(exp_q.size() + out_q.size()), 0);
  endtask

  // Decoder: ready dec_lat cycles into a job (1 = first RUN cycle), never when the job is hung.
  initial begin
    dec_ready = 1'b0;
    dec_out   = 4'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!start || !dec_start) begin
        dec_ready = spur;
        run_cnt   = 0;
      end else begin
        run_cnt++;
        if (run_cnt == 1) job_hang = dec_hang;
        if (!job_hang && run_cnt >= dec_lat) begin
          dec_ready = 1'b1;
          dec_out   = ref_dec(dec_data);
        end else begin
          dec_ready = 1'b0;
        end
      end
    end
  end

  // Scoreboard: every job issue must be the oldest accepted word; every handshake the oldest nibble.
  always @(negedge clk) begin
    if (!start) begin
      ds_prev = 1'b0;
    end else begin
      if (mon_en && dec_start && !ds_prev) begin
        chk("issue_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_w = exp_q.pop_front();
          chk("dec_data", dec_data, mon_w);
          if (!dec_hang) out_q.push_back(ref_dec(mon_w));
        end
      end
      if (mon_en && out_valid && out_ready) begin
        chk("out_expected", 32'(out_q.size() > 0), 1);
        if (out_q.size() > 0) chk("out_data", out_data, out_q.pop_front());
        n_out++;
      end
      ds_prev = dec_start;
    end
  end

  initial begin : main
    bit         ok;
    int         occ;
    bit         full_exp;
    logic [3:0] held;
    logic [7:0] b;

    start     = 1'b0;
    in_valid  = 1'b0;
    in_word   = 9'h0;
    out_ready = 1'b0;
    #12;
    chk("rst_in_full", in_full, 0);
    chk("rst_dec_start", dec_start, 0);
    chk("rst_dec_data", dec_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err_tmo", err_tmo, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    tick;
    start = 1'b1;
    tick;

    // Single job timing: 0xA5, ready 5 cycles after dec_start rises.
    dec_lat = 6;
    send(mkw(8'hA5));
    chk("t1_idle_ds", dec_start, 0);
    tick;
    chk("t1_clear_ds", dec_start, 0);
    chk("t1_dec_data", dec_data, 8'hA5);
    tick;
    chk("t1_clear2_ds", dec_start, 0);
    tick;
    chk("t1_run_ds", dec_start, 1);
    repeat (5) tick;
    chk("t1_ov_before_ready", out_valid, 0);
    tick;
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_data", out_data, 4'h9);
    chk("t1_hold_ds", dec_start, 0);
    ok = 1'b1;
    repeat (3) begin tick; ok &= out_valid && (out_data == 4'h9); end
    chk("t1_hold_stable", ok, 1);
    out_ready = 1'b1;
    tick;
    chk("t1_ov_after_hs", out_valid, 0);
    ok = 1'b1;
    repeat (CLR_CYC + 2) begin tick; ok &= !dec_start; end
    chk("t1_stays_idle", ok, 1);

    // dec_ready outside RUN must be ignored.
    spur = 1'b1;
    ok = 1'b1;
    repeat (10) begin tick; ok &= !out_valid && !dec_start; end
    spur = 1'b0;
    tick;
    chk("spurious_ready_ignored", ok, 1);

    // Consumer stalls 20 cycles with a second word queued.
    dec_lat   = 2;
    out_ready = 1'b0;
    send(mkw(8'h3C));
    send(mkw(8'hE1));
    wait_out(40);
    held = out_data;
    ok = 1'b1;
    repeat (20) begin tick; ok &= out_valid && (out_data == held) && !dec_start; end
    chk("t4_hold_stable", ok, 1);
    out_ready = 1'b1;
    tick;
    chk("t4_ov_after_hs", out_valid, 0);
    drain(100);

    // Burst of 6 back-to-back words against a slow decoder.
    dec_lat = 40;
    occ = 0;
    for (int k = 0; k < 6; k++) begin
      full_exp = (occ == DEPTH);
      drive_word(mkw(8'(8'h10 + k * 8'h13)), full_exp);
      if (!full_exp) occ++;
      if (k == 1) occ--;
    end
    in_valid = 1'b0;
    chk("t2_in_full", in_full, (occ == DEPTH));
    chk("t2_drop_cnt", drop_cnt, exp_drop[7:0]);
    drain(500);

    // Hung decoder: timeout, sticky error, next queued word still served.
    dec_lat  = 3;
    dec_hang = 1'b1;
    send(mkw(8'h5A));
    send(mkw(8'h77));
    wait_ds(20);
    tick;
    dec_hang = 1'b0;
    chk("t3_err_early", err_tmo, 0);
    ok = 1'b1;
    repeat (200) begin tick; ok &= !out_valid && !err_tmo; end
    chk("t3_no_output_no_err", ok, 1);
    begin
      int n = 0;
      while (!err_tmo && n < 100) begin tick; n++; end
    end
    chk("t3_err_tmo", err_tmo, 1);
    wait_out(40);
    drain(50);
    chk("t3_err_sticky", err_tmo, 1);

    // Reset in RUN with a second word queued.
    dec_lat = 20;
    send(mkw(8'h81));
    send(mkw(8'h42));
    wait_ds(20);
    tick;
    tick;
    #2;
    start = 1'b0;
    #1;
    chk("t5_ds_async", dec_start, 0);
    chk("t5_ov_async", out_valid, 0);
    chk("t5_err_cleared", err_tmo, 0);
    tick;
    start = 1'b1;
    exp_q.delete();
    out_q.delete();
    n_acc = 0;
    n_out = 0;
    exp_drop = 0;
    ok = 1'b1;
    repeat (20) begin tick; ok &= !dec_start && !in_full; end
    chk("t5_fifo_empty", ok, 1);
    chk("t5_drop_cnt", drop_cnt, 0);

    // Parity: 0x03 with bit8=1, then 0x03 with bit8=0.
    dec_lat = 2;
    send(9'h103);
    send(9'h003);
    drain(100);
    chk("t6_drop_cnt", drop_cnt, exp_drop[7:0]);

    // Random traffic, never overrunning the FIFO.
    for (int i = 0; i < 400; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      dec_lat   = $urandom_range(1, 5);
      if ((n_acc - n_out) < DEPTH && $urandom_range(0, 2) == 0) begin
        b = 8'($urandom);
        send({1'($urandom_range(0, 1)), b});
      end else begin
        tick;
      end
    end
    out_ready = 1'b1;
    drain(300);
    chk("rand_drop_cnt", drop_cnt, exp_drop[7:0]);
    chk("rand_out_count", n_out, n_acc);

    // Saturation: long stream into a full FIFO behind a hung decoder.
    mon_en   = 1'b0;
    dec_hang = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1;
      in_word  = mkw(8'(i));
      tick;
    end
    in_valid = 1'b0;
    tick;
    chk("drop_cnt_saturated", drop_cnt, 8'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
